ack_fifo_ctrl: RTL and testbench

//  Sequences the 64x16 dual-read/single-write uSRAM macro as a synchronous ACK FIFO.

---
 rtl/ack_fifo_if.sv | 43 ++++
 rtl/ack_fifo_ctrl.sv | 122 ++++++++++++
 tb/tb_ack_fifo_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ack_fifo_if.sv
// rtl/ack_fifo_if.sv - bus bundle between the ACK FIFO controller, its user and the uSRAM
// Purpose: groups the push/pop handshake, status outputs and the RAM port A/C strobes.
// Ports (slave = controller side):
//   in : clear, wr_en, wr_data, rd_ready, ram_a_dout
//   out: full, afull, rd_valid, rd_data, count, overflow,
//        ram_c_addr, ram_c_din, ram_c_wen, ram_c_blk, ram_a_addr, ram_a_addr_en, ram_a_blk
interface ack_fifo_if #(
   parameter int AW = 6,
   parameter int DW = 16
);
   logic          clear;
   logic          wr_en;
   logic [DW-1:0] wr_data;
   logic          full;
   logic          afull;
   logic          rd_valid;
   logic [DW-1:0] rd_data;
   logic          rd_ready;
   logic [AW+1:0] count;
   logic          overflow;
   logic [AW-1:0] ram_c_addr;
   logic [DW-1:0] ram_c_din;
   logic          ram_c_wen;
   logic          ram_c_blk;
   logic [AW-1:0] ram_a_addr;
   logic          ram_a_addr_en;
   logic          ram_a_blk;
   logic [DW-1:0] ram_a_dout;

   modport slave (
      input  clear, wr_en, wr_data, rd_ready, ram_a_dout,
      output full, afull, rd_valid, rd_data, count, overflow,
             ram_c_addr, ram_c_din, ram_c_wen, ram_c_blk,
             ram_a_addr, ram_a_addr_en, ram_a_blk
   );

   modport master (
      output clear, wr_en, wr_data, rd_ready, ram_a_dout,
      input  full, afull, rd_valid, rd_data, count, overflow,
             ram_c_addr, ram_c_din, ram_c_wen, ram_c_blk,
             ram_a_addr, ram_a_addr_en, ram_a_blk
   );
endinterface

// File: rtl/ack_fifo_ctrl.sv
// rtl/ack_fifo_ctrl.sv - ACK FIFO sequencer around a 64x16 dual-read/single-write uSRAM
// Purpose: owns write/read pointers, pushes through RAM port C, prefetches through
//   RAM port A into a 2-entry output buffer presented as valid/ready.
// Ports:
//   clk   - single clock (also the RAM port A/C clock)
//   rst_n - asynchronous active-low reset
//   bus   - ack_fifo_if.slave: push side, pop side, status and RAM strobes
module ack_fifo_ctrl #(
   parameter int AW        = 6,
   parameter int DW        = 16,
   parameter int AFULL_LVL = 56
) (
   input  logic       clk,
   input  logic       rst_n,
   ack_fifo_if.slave  bus
);
   localparam logic [AW:0] AFULL_THR = (AW+1)'(AFULL_LVL);
   localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);

   logic [AW:0]   wptr;
   logic [AW:0]   rptr;
   logic [AW:0]   mem_occ;
   logic          inflight;
   logic [1:0]    ob_cnt;
   logic [DW-1:0] ob_head;
   logic [DW-1:0] ob_tail;
   logic          overflow_q;

   logic          full;
   logic          push;
   logic          pop;
   logic          fetch;
   logic          capture;
   logic [2:0]    pending;

   // Pointers carry one wrap bit, so the difference is the true occupancy 0..DEPTH.
   assign mem_occ = wptr - rptr;
   assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

   // Buffer slots that will be taken once the in-flight word lands, net of this cycle's pop.
   assign pending = {1'b0, ob_cnt} + {2'b00, inflight} - {2'b00, pop};

   // rst_n gating keeps every RAM strobe low while reset is held, even with wr_en high.
   assign push    = rst_n && bus.wr_en && !full && !bus.clear;
   assign pop     = (ob_cnt != 2'd0) && bus.rd_ready;
   assign fetch   = rst_n && (mem_occ != '0) && (pending < 3'd2) && !bus.clear;
   // A word arriving in a CLEAR cycle belongs to the flushed contents and is dropped.
   assign capture = inflight && !bus.clear;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr       <= '0;
         rptr       <= '0;
         inflight   <= 1'b0;
         ob_cnt     <= 2'd0;
         ob_head    <= '0;
         ob_tail    <= '0;
         overflow_q <= 1'b0;
      end else if (bus.clear) begin
         wptr       <= '0;
         rptr       <= '0;
         inflight   <= 1'b0;
         ob_cnt     <= 2'd0;
         ob_head    <= '0;
         ob_tail    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) begin
            wptr <= wptr + PTR_ONE;
         end
         if (bus.wr_en && full) begin
            overflow_q <= 1'b1;
         end
         if (fetch) begin
            rptr <= rptr + PTR_ONE;
         end
         // RAM read data is valid exactly one cycle after the fetch edge.
         inflight <= fetch;

         case ({capture, pop})
            2'b10: begin
               if (ob_cnt == 2'd0) begin
                  ob_head <= bus.ram_a_dout;
               end else begin
                  ob_tail <= bus.ram_a_dout;
               end
               ob_cnt <= ob_cnt + 2'd1;
            end
            2'b01: begin
               ob_head <= ob_tail;
               ob_cnt  <= ob_cnt - 2'd1;
            end
            2'b11: begin
               // Count unchanged; the new word goes behind whatever remains after the pop.
               if (ob_cnt == 2'd1) begin
                  ob_head <= bus.ram_a_dout;
               end else begin
                  ob_head <= ob_tail;
                  ob_tail <= bus.ram_a_dout;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.full          = full;
   assign bus.afull         = (mem_occ >= AFULL_THR);
   assign bus.rd_valid      = (ob_cnt != 2'd0);
   assign bus.rd_data       = ob_head;
   assign bus.count         = {1'b0, mem_occ} + (AW+2)'(ob_cnt) + (AW+2)'(inflight);
   assign bus.overflow      = overflow_q;

   assign bus.ram_c_addr    = wptr[AW-1:0];
   assign bus.ram_c_din     = bus.wr_data;
   assign bus.ram_c_wen     = push;
   assign bus.ram_c_blk     = push;
   assign bus.ram_a_addr    = rptr[AW-1:0];
   assign bus.ram_a_addr_en = fetch;
   assign bus.ram_a_blk     = fetch;
endmodule

// File: tb/tb_ack_fifo_ctrl.sv
// tb/tb_ack_fifo_ctrl.sv - self-checking bench for ack_fifo_ctrl with a uSRAM model
module tb_ack_fifo_ctrl;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   ack_fifo_if #(.AW(6), .DW(16)) bus ();

   ack_fifo_ctrl #(.AW(6), .DW(16), .AFULL_LVL(56)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // uSRAM: port C synchronous write, port A registered read (data the cycle after).
   logic [15:0] ram [0:63];
   always @(posedge clk) begin
      if (bus.ram_c_wen) ram[bus.ram_c_addr] <= bus.ram_c_din;
      if (bus.ram_a_addr_en) bus.ram_a_dout <= ram[bus.ram_a_addr];
   end

   int wraps = 0;
   always @(posedge clk) begin
      if (bus.ram_c_wen && bus.ram_c_addr == 6'd63) wraps <= wraps + 1;
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
      end
   endtask

   task automatic drive(input logic we, input logic [15:0] d, input logic rr, input logic clr);
      bus.wr_en    = we;
      bus.wr_data  = d;
      bus.rd_ready = rr;
      bus.clear    = clr;
   endtask

   // Reference: every accepted word is visible exactly 3 cycles after its push, and is
   // popped in order; occupancy is simply accepted minus popped.
   typedef struct {
      logic [15:0] d;
      int          t;
   } ent_t;
   ent_t q[$];
   int   cyc = 0;

   task automatic model_cycle(input logic we, input logic [15:0] d, input logic rr);
      logic exp_v;
      drive(we, d, rr, 1'b0);
      @(negedge clk);
      exp_v = (q.size() > 0) && (q[0].t <= cyc - 3);
      chk("m_valid", bus.rd_valid, exp_v);
      if (exp_v) chk("m_data", bus.rd_data, q[0].d);
      chk("m_count", bus.count, q.size());
      chk("m_full", bus.full, 1'b0);
      if (exp_v && rr) void'(q.pop_front());
      if (we) q.push_back('{d, cyc});
      cyc++;
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic        we;
      logic [15:0] d;
      logic        rr;
      logic        e_cwen;
      logic [5:0]  e_caddr;
      logic        e_aen;
      logic        e_valid;
      logic [15:0] e_data;
      int          e_count;
   } vec_t;
   vec_t tbl[9];

   task automatic run_table();
      for (int i = 0; i < 9; i++) begin
         drive(tbl[i].we, tbl[i].d, tbl[i].rr, 1'b0);
         @(negedge clk);
         chk($sformatf("t%0d_cwen", i), bus.ram_c_wen, tbl[i].e_cwen);
         chk($sformatf("t%0d_cblk", i), bus.ram_c_blk, tbl[i].e_cwen);
         if (tbl[i].e_cwen) chk($sformatf("t%0d_caddr", i), bus.ram_c_addr, tbl[i].e_caddr);
         chk($sformatf("t%0d_aen", i), bus.ram_a_addr_en, tbl[i].e_aen);
         chk($sformatf("t%0d_valid", i), bus.rd_valid, tbl[i].e_valid);
         if (tbl[i].e_valid) chk($sformatf("t%0d_data", i), bus.rd_data, tbl[i].e_data);
         chk($sformatf("t%0d_count", i), bus.count, tbl[i].e_count);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      int n;
      int w0;
      logic we;

      //         we  data      rr  cwen caddr aen valid data     count
      tbl[0] = '{1'b1, 16'h1234, 1'b1, 1'b1, 6'd0, 1'b0, 1'b0, 16'h0000, 0};
      tbl[1] = '{1'b0, 16'h0000, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0, 16'h0000, 1};
      tbl[2] = '{1'b0, 16'h0000, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 16'h0000, 1};
      tbl[3] = '{1'b0, 16'h0000, 1'b1, 1'b0, 6'd0, 1'b0, 1'b1, 16'h1234, 1};
      tbl[4] = '{1'b1, 16'habcd, 1'b1, 1'b1, 6'd1, 1'b0, 1'b0, 16'h0000, 0};
      tbl[5] = '{1'b0, 16'h0000, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0, 16'h0000, 1};
      tbl[6] = '{1'b0, 16'h0000, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 16'h0000, 1};
      tbl[7] = '{1'b0, 16'h0000, 1'b1, 1'b0, 6'd0, 1'b0, 1'b1, 16'habcd, 1};
      tbl[8] = '{1'b0, 16'h0000, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 16'h0000, 0};

      // Reset state
      rst_n = 1'b0;
      drive(1'b1, 16'hffff, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_count", bus.count, 0);
      chk("rst_full", bus.full, 1'b0);
      chk("rst_afull", bus.afull, 1'b0);
      chk("rst_valid", bus.rd_valid, 1'b0);
      chk("rst_data", bus.rd_data, 16'h0000);
      chk("rst_ovf", bus.overflow, 1'b0);
      chk("rst_cwen", bus.ram_c_wen, 1'b0);
      chk("rst_aen", bus.ram_a_addr_en, 1'b0);
      drive(1'b0, 16'h0000, 1'b0, 1'b0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Single push latency
      run_table();

      // Continuous 1/clk streaming with pointer wrap
      w0 = wraps;
      for (int k = 0; k < 200; k++) model_cycle(1'b1, 16'(k + 16'h0300), 1'b1);
      for (int k = 0; k < 6; k++) model_cycle(1'b0, 16'h0000, 1'b1);
      chk("wraps_ge_3", (wraps - w0) >= 3, 1'b1);

      // Random push/pop against the reference model
      for (int k = 0; k < 400; k++) begin
         we = (q.size() < 50) ? 1'($urandom % 2) : 1'b0;
         model_cycle(we, 16'($urandom), 1'($urandom % 2));
      end
      for (int k = 0; k < 70; k++) model_cycle(1'b0, 16'h0000, 1'b1);

      // Fill to FULL with the reader stalled, then overflow
      for (int i = 0; i < 66; i++) begin
         drive(1'b1, 16'(i), 1'b0, 1'b0);
         @(negedge clk);
         chk($sformatf("fill%0d_count", i), bus.count, i);
         chk($sformatf("fill%0d_full", i), bus.full, 1'b0);
         chk($sformatf("fill%0d_afull", i), bus.afull, (i >= 58));
         @(posedge clk); #1;
      end
      drive(1'b1, 16'hdead, 1'b0, 1'b0);
      @(negedge clk);
      chk("full_set", bus.full, 1'b1);
      chk("full_count", bus.count, 66);
      chk("full_afull", bus.afull, 1'b1);
      chk("full_nowrite", bus.ram_c_wen, 1'b0);
      chk("full_ovf_pre", bus.overflow, 1'b0);
      @(posedge clk); #1;
      drive(1'b0, 16'h0000, 1'b0, 1'b0);
      @(negedge clk);
      chk("ovf_set", bus.overflow, 1'b1);
      chk("ovf_count", bus.count, 66);
      @(posedge clk); #1;
      n = 0;
      for (int k = 0; k < 150 && n < 66; k++) begin
         drive(1'b0, 16'h0000, 1'b1, 1'b0);
         @(negedge clk);
         if (bus.rd_valid) begin
            chk($sformatf("drain%0d", n), bus.rd_data, n);
            n++;
         end
         @(posedge clk); #1;
      end
      chk("drain_words", n, 66);
      drive(1'b0, 16'h0000, 1'b0, 1'b0);
      @(negedge clk);
      chk("drain_count", bus.count, 0);
      chk("ovf_sticky", bus.overflow, 1'b1);
      @(posedge clk); #1;

      // CLEAR with a fetch in flight and a loaded buffer
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 16'(16'h0a01 + i), 1'b0, 1'b0);
         @(posedge clk); #1;
      end
      drive(1'b0, 16'h0000, 1'b0, 1'b0);
      @(posedge clk); #1;
      drive(1'b0, 16'h0000, 1'b1, 1'b0);
      @(negedge clk);
      chk("clr_pre_valid", bus.rd_valid, 1'b1);
      chk("clr_pre_data", bus.rd_data, 16'h0a01);
      chk("clr_pre_count", bus.count, 3);
      @(posedge clk); #1;
      drive(1'b1, 16'hbbbb, 1'b1, 1'b1);
      @(negedge clk);
      chk("clr_head", bus.rd_data, 16'h0a02);
      chk("clr_cwen", bus.ram_c_wen, 1'b0);
      chk("clr_aen", bus.ram_a_addr_en, 1'b0);
      @(posedge clk); #1;
      drive(1'b0, 16'h0000, 1'b1, 1'b0);
      @(negedge clk);
      chk("clr_count", bus.count, 0);
      chk("clr_valid", bus.rd_valid, 1'b0);
      chk("clr_ovf", bus.overflow, 1'b0);
      chk("clr_full", bus.full, 1'b0);
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk($sformatf("clr_stale%0d", k), bus.rd_valid, 1'b0);
         @(posedge clk); #1;
      end
      q.delete();
      cyc = 0;
      for (int k = 0; k < 5; k++) model_cycle(k == 0, 16'h5555, 1'b1);

      // Asynchronous reset mid-burst
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0);
         @(posedge clk); #1;
      end
      chk("arst_pre_valid", bus.rd_valid, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_count", bus.count, 0);
      chk("arst_valid", bus.rd_valid, 1'b0);
      chk("arst_data", bus.rd_data, 16'h0000);
      chk("arst_full", bus.full, 1'b0);
      chk("arst_ovf", bus.overflow, 1'b0);
      chk("arst_cwen", bus.ram_c_wen, 1'b0);
      chk("arst_aen", bus.ram_a_addr_en, 1'b0);
      @(posedge clk);
      @(negedge clk);
      chk("arst_hold_cwen", bus.ram_c_wen, 1'b0);
      chk("arst_hold_count", bus.count, 0);
      drive(1'b0, 16'h0000, 1'b0, 1'b0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_table();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
